gray_ptr_receiver: RTL and testbench



---
 rtl/fifo_ptr_pkg.sv | 32 +++
 rtl/gray_to_bin.sv | 19 +
 rtl/gray_ptr_receiver.sv | 79 +++++++
 tb/tb_gray_ptr_receiver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO pointer path: gray decode, popcount, depth.
// Pure functions and constants; no state, no latency.
package fifo_ptr_pkg;

  localparam int unsigned PTR_MAX_W = 32;
  localparam int unsigned PTR_WIDTH = 8;
  localparam int unsigned DEPTH     = 2 ** (PTR_WIDTH - 1);

  // Zero-extended inputs decode correctly because leading zeros leave the prefix XOR unchanged.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [PTR_MAX_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  function automatic int unsigned depth_of(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary decoder, WIDTH <= 32.
// Zero latency; no flow control.
module gray_to_bin
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [PTR_MAX_W-1:0] gray_ext;
  logic [PTR_MAX_W-1:0] bin_ext;

  assign gray_ext = PTR_MAX_W'(gray_i);
  assign bin_ext  = gray2bin(gray_ext);
  assign bin_o    = bin_ext[WIDTH-1:0];

endmodule

// File: rtl/gray_ptr_receiver.sv
// Synchronises a remote gray pointer, decodes it and derives fill level / empty flags.
// bin_sync lags a stable gray_in by SYNC_STAGES+1 edges; no handshake, remote must step one bit at a time.
module gray_ptr_receiver
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic [WIDTH-1:0] local_ptr,
  output logic [WIDTH-1:0] bin_sync,
  output logic [WIDTH-1:0] level,
  output logic             empty,
  output logic             almost_empty,
  output logic             ptr_upd,
  output logic             ptr_err
);

  localparam logic [WIDTH:0]   DEPTH_W = (WIDTH + 1)'(depth_of(WIDTH));
  localparam logic [WIDTH-1:0] AE_W    = WIDTH'(AE_THRESH);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0]                  gray_last_q;
  logic [WIDTH-1:0]                  gray_last_d;
  logic                              ptr_upd_q;
  logic                              ptr_upd_d;
  logic                              ptr_err_q;
  logic                              ptr_err_d;
  logic                              multi_bit;
  logic                              overrun;

  genvar g;
  generate
    for (g = 0; g < SYNC_STAGES; g++) begin : g_sync
      if (g == 0) begin : g_first
        assign sync_d[g] = gray_in;
      end else begin : g_next
        assign sync_d[g] = sync_q[g-1];
      end
    end
  endgenerate

  // Stage-to-stage compare sees what gray_last is about to load, so errors land on that same edge.
  assign multi_bit   = popcount(PTR_MAX_W'(sync_q[SYNC_STAGES-1] ^ gray_last_q)) > 6'd1;
  assign overrun     = {1'b0, level} > DEPTH_W;
  assign gray_last_d = sync_q[SYNC_STAGES-1];
  assign ptr_upd_d   = sync_q[SYNC_STAGES-1] != gray_last_q;
  assign ptr_err_d   = ptr_err_q | multi_bit | overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      gray_last_q <= '0;
      ptr_upd_q   <= 1'b0;
      ptr_err_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      gray_last_q <= gray_last_d;
      ptr_upd_q   <= ptr_upd_d;
      ptr_err_q   <= ptr_err_d;
    end
  end

  gray_to_bin #(.WIDTH(WIDTH)) u_decode (
    .gray_i (gray_last_q),
    .bin_o  (bin_sync)
  );

  assign level        = bin_sync - local_ptr;
  assign empty        = level == '0;
  assign almost_empty = level <= AE_W;
  assign ptr_upd      = ptr_upd_q;
  assign ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Randomised and directed bench for gray_ptr_receiver against a sample-history reference model.
module tb_gray_ptr_receiver;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic [3:0] local_ptr;
  logic [3:0] bin_sync;
  logic [3:0] level;
  logic       empty;
  logic       almost_empty;
  logic       ptr_upd;
  logic       ptr_err;

  int nvec = 0;
  int nerr = 0;

  gray_ptr_receiver #(.WIDTH(4), .SYNC_STAGES(2), .AE_THRESH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gray_in      (gray_in),
    .local_ptr    (local_ptr),
    .bin_sync     (bin_sync),
    .level        (level),
    .empty        (empty),
    .almost_empty (almost_empty),
    .ptr_upd      (ptr_upd),
    .ptr_err      (ptr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every gray_in sample taken since reset; the decoded output is the one taken three edges ago.
  logic [3:0] hist[$];
  bit         m_err;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int from_gray(input logic [3:0] gv);
    for (int b = 0; b < 16; b++) begin
      if (to_gray(b) == int'(gv)) return b;
    end
    return -1;
  endfunction

  function automatic int m_bin();
    return from_gray(hist[$-2]);
  endfunction

  function automatic int m_level();
    return (m_bin() - int'(local_ptr)) & 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = {};
    repeat (6) hist.push_back(4'd0);
    m_err = 1'b0;
  endtask

  task automatic check_all();
    chk("bin_sync", 32'(bin_sync), 32'(m_bin()));
    chk("level", 32'(level), 32'(m_level()));
    chk("empty", 32'(empty), 32'(m_level() == 0));
    chk("almost_empty", 32'(almost_empty), 32'(m_level() <= 2));
    chk("ptr_upd", 32'(ptr_upd), 32'(hist[$-2] != hist[$-3]));
    chk("ptr_err", 32'(ptr_err), 32'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) begin
      if (m_level() > 8) m_err = 1'b1;
      hist.push_back(gray_in);
      if (hist.size() > 8) void'(hist.pop_front());
      if ($countones(hist[$-2] ^ hist[$-3]) > 1) m_err = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input int gv, input int lp);
    gray_in   = 4'(gv);
    local_ptr = 4'(lp);
    #1;
    check_all();
  endtask

  // Called just after a falling edge; asserts reset well before the next rising edge.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_err", 32'(ptr_err), 32'd0);
    chk("rst_bin", 32'(bin_sync), 32'd0);
    chk("rst_upd", 32'(ptr_upd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb;
    int lp;
    rst_n     = 1'b0;
    gray_in   = 4'b0110;
    local_ptr = 4'd0;
    model_reset();

    // Reset held with a nonzero remote pointer.
    #3;
    check_all();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("rel_hold_bin", 32'(bin_sync), 32'd0);
    cyc();
    chk("rel_bin", 32'(bin_sync), 32'd4);
    cyc();

    // Counting 0..5.
    apply_reset();
    for (int b = 0; b < 6; b++) begin
      drive(to_gray(b), 0);
      cyc();
    end
    repeat (3) cyc();
    chk("cnt_level", 32'(level), 32'd5);
    chk("cnt_empty", 32'(empty), 32'd0);
    chk("cnt_ae", 32'(almost_empty), 32'd0);
    chk("cnt_err", 32'(ptr_err), 32'd0);

    // Wrap 15 -> 0 against local pointer 14.
    apply_reset();
    drive(4'b1000, 14);
    repeat (4) cyc();
    chk("wrap_level1", 32'(level), 32'd1);
    drive(4'b0000, 14);
    repeat (4) cyc();
    chk("wrap_level2", 32'(level), 32'd2);
    chk("wrap_ae", 32'(almost_empty), 32'd1);
    chk("wrap_empty", 32'(empty), 32'd0);
    chk("wrap_err", 32'(ptr_err), 32'd0);

    // Same-cycle pop.
    apply_reset();
    drive(to_gray(3), 2);
    repeat (4) cyc();
    chk("pop_level1", 32'(level), 32'd1);
    drive(to_gray(3), 3);
    chk("pop_level0", 32'(level), 32'd0);
    chk("pop_empty", 32'(empty), 32'd1);
    cyc();

    // Two-bit violation.
    apply_reset();
    drive(4'b0000, 0);
    cyc();
    drive(4'b0011, 0);
    cyc();
    cyc();
    chk("viol_pre", 32'(ptr_err), 32'd0);
    cyc();
    chk("viol_set", 32'(ptr_err), 32'd1);
    drive(4'b0010, 0);
    cyc();
    drive(4'b0110, 0);
    repeat (4) cyc();
    chk("viol_sticky", 32'(ptr_err), 32'd1);

    // Overrun to bin 9, then mid-run reset.
    apply_reset();
    for (int b = 0; b < 10; b++) begin
      drive(to_gray(b), 0);
      cyc();
    end
    cyc();
    cyc();
    chk("ovr_at8", 32'(ptr_err), 32'd0);
    cyc();
    cyc();
    chk("ovr_level", 32'(level), 32'd9);
    chk("ovr_err", 32'(ptr_err), 32'd1);
    apply_reset();
    chk("ovr_rst_empty", 32'(empty), 32'd1);
    repeat (4) cyc();

    // Random traffic with occasional violations, overruns and resets.
    rb = 0;
    lp = 0;
    apply_reset();
    drive(0, 0);
    for (int n = 0; n < 600; n++) begin
      if (n % 75 == 74) begin
        apply_reset();
        rb = 0;
        lp = 0;
        drive(0, 0);
      end
      if ($urandom_range(0, 59) == 0) begin
        drive(int'($urandom_range(0, 15)), lp);
        rb = from_gray(gray_in);
      end else begin
        if ($urandom_range(0, 2) != 0 && (((rb - lp) & 15) < 8 || $urandom_range(0, 19) == 0))
          rb = (rb + 1) & 15;
        if (m_level() > 0 && $urandom_range(0, 2) != 0)
          lp = (lp + 1) & 15;
        drive(to_gray(rb), lp);
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
